zx_cegen: RTL and testbench

//  Parametrised clock-enable generator for the ZX48 core: derives video (7 MHz) and CPU (3.5 MHz
//  and turbo) enables from the 56 MHz master clock. Applies ULA memory/IO contention and generates
//  the power-on delay. Successor of the fixed /16 divider in the top level: adds selectable turbo

---
 rtl/zx_cegen.sv | 122 ++++++++++++
 tb/tb_zx_cegen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/zx_cegen.sv
// zx_cegen: clock-enable generator for the ZX48 core.
// Derives the video (7 MHz) and CPU (3.5 MHz plus turbo) enables from the 56 MHz
// master clock. It applies ULA memory/IO contention in the base mode and
// produces the power-on delay flag.
//
// The block has no valid/ready handshakes. Every output is a single-cycle
// enable or a level. While reset is low, all outputs are forced to zero.
//
// Turbo changes take effect only at the cnt all-ones -> 0 boundary. Every
// divisor is a power of two that divides 2^CE_BITS, so each mode starts its
// cen phase at cnt==0. For this reason, a switch can never split a cep/cen pair.
module zx_cegen #(
  parameter int CE_BITS    = 4,
  parameter int VID_BITS   = 3,
  parameter int POR_BITS   = 6,
  parameter int CONTEND_EN = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] turbo,
  input  logic       vduCn,
  input  logic       mreq,
  input  logic       ioula,
  input  logic [1:0] ah,
  output logic       ce7M0p,
  output logic       ce7M0n,
  output logic       cep,
  output logic       cen,
  output logic [1:0] mode,
  output logic       stall,
  output logic       power
);

  // Fastest allowed mode keeps at least one divider bit (k = CE_BITS - mode >= 1).
  localparam logic [1:0] MODE_MAX = (CE_BITS - 1 > 3) ? 2'd3 : 2'(CE_BITS - 1);
  localparam logic [VID_BITS-1:0] VID_HALF = VID_BITS'(1 << (VID_BITS - 1));

  logic [CE_BITS-1:0]  cnt;
  logic [1:0]          mode_q;
  logic                cpuck;
  logic                samp;
  logic [POR_BITS-1:0] por;

  logic [1:0]          turbo_clamped;
  logic [CE_BITS-1:0]  base_mask;
  logic [CE_BITS-1:0]  base_half;
  logic [CE_BITS-1:0]  base_phase;
  logic                basen;
  logic                basep;
  logic                vid_n;
  logic                vid_p;
  logic                contend;

  // Clamp the requested turbo mode to the range the counter width supports.
  always_comb begin
    turbo_clamped = turbo;
    if (turbo > MODE_MAX) turbo_clamped = MODE_MAX;
  end

  // Base CPU enables: the low k bits of cnt give one period of the current mode.
  always_comb begin
    base_mask  = {CE_BITS{1'b1}} >> mode_q;
    base_half  = (base_mask >> 1) + CE_BITS'(1);
    base_phase = cnt & base_mask;
    basen      = (base_phase == '0);
    basep      = (base_phase == base_half);
  end

  // Video enables: fixed divider, never contended.
  always_comb begin
    vid_n = (cnt[VID_BITS-1:0] == '0);
    vid_p = (cnt[VID_BITS-1:0] == VID_HALF);
  end

  // ULA contention: only applies in the base (non-turbo) mode. contend=0 holds the CPU.
  always_comb begin
    contend = 1'b1;
    if ((CONTEND_EN != 0) && (mode_q == 2'd0))
      contend = !(vduCn & cpuck & samp & ((ah == 2'b01) | !ioula));
  end

  // Output gating: all outputs are held low while reset is asserted.
  always_comb begin
    ce7M0n = reset & vid_n;
    ce7M0p = reset & vid_p;
    cep    = reset & basep & contend;
    cen    = reset & basen & contend;
    stall  = reset & (basep | basen) & !contend;
    mode   = reset ? mode_q : 2'd0;
    power  = reset & por[POR_BITS-1];
  end

  // Free-running divider counter.
  always_ff @(posedge clock) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  // Mode latch: a turbo request is taken only on the last count of a period.
  always_ff @(posedge clock) begin
    if (!reset)     mode_q <= 2'd0;
    else if (&cnt)  mode_q <= turbo_clamped;
  end

  // Contention state: sample the bus cycle on cep and track the ULA clock phase on ce7M0n.
  always_ff @(posedge clock) begin
    if (!reset) begin
      samp  <= 1'b0;
      cpuck <= 1'b0;
    end else begin
      if (cep)    samp  <= mreq & ioula;
      if (ce7M0n) cpuck <= !(cpuck & contend);
    end
  end

  // Power-on delay: count delivered CPU enables until the MSB sets, then hold.
  always_ff @(posedge clock) begin
    if (!reset)                          por <= '0;
    else if (cep && !por[POR_BITS-1])    por <= por + 1'b1;
  end

endmodule

// File: tb/tb_zx_cegen.sv
// tb_zx_cegen: bench for zx_cegen. Covers uncontended mode sequencing, turbo
// switching, contention, the CONTEND_EN=0 variant and the power-on delay.
module tb_zx_cegen;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] turbo = 2'd0;
  logic       vduCn = 1'b0;
  logic       mreq  = 1'b1;
  logic       ioula = 1'b1;
  logic [1:0] ah    = 2'd0;

  always #5 clock = ~clock;

  logic       ce7M0p, ce7M0n, cep, cen, stall, power;
  logic [1:0] mode;
  logic       nc_ce7M0p, nc_ce7M0n, nc_cep, nc_cen, nc_stall, nc_power;
  logic [1:0] nc_mode;

  zx_cegen #(.CE_BITS(4), .VID_BITS(3), .POR_BITS(6), .CONTEND_EN(1)) dut (
    .clock(clock), .reset(reset), .turbo(turbo), .vduCn(vduCn), .mreq(mreq),
    .ioula(ioula), .ah(ah), .ce7M0p(ce7M0p), .ce7M0n(ce7M0n), .cep(cep),
    .cen(cen), .mode(mode), .stall(stall), .power(power)
  );

  zx_cegen #(.CE_BITS(4), .VID_BITS(3), .POR_BITS(6), .CONTEND_EN(0)) dut_nc (
    .clock(clock), .reset(reset), .turbo(turbo), .vduCn(vduCn), .mreq(mreq),
    .ioula(ioula), .ah(ah), .ce7M0p(nc_ce7M0p), .ce7M0n(nc_ce7M0n), .cep(nc_cep),
    .cen(nc_cen), .mode(nc_mode), .stall(nc_stall), .power(nc_power)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];   // {ce7M0p, ce7M0n, cep, cen, mode[1:0], stall, power}

  // Reference model state for the uncontended case
  int m_cnt  = 0;
  int m_mode = 0;
  int m_por  = 0;

  int phase_ceps;
  logic [1:0] last_mode;
  int c_cep, c_cen, c_stall, nc_c_cep, nc_c_stall;

  function automatic logic [7:0] pack_out();
    return {ce7M0p, ce7M0n, cep, cen, mode, stall, power};
  endfunction

  function automatic logic [7:0] pack_nc();
    return {nc_ce7M0p, nc_ce7M0n, nc_cep, nc_cen, nc_mode, nc_stall, nc_power};
  endfunction

  function automatic logic [7:0] model_out();
    int per;
    logic e_p, e_n, e_cep, e_cen, e_pw;
    per   = 1 << (4 - m_mode);
    e_n   = (m_cnt % 8) == 0;
    e_p   = (m_cnt % 8) == 4;
    e_cen = (m_cnt % per) == 0;
    e_cep = (m_cnt % per) == (per / 2);
    e_pw  = (m_por >= 32);
    return {e_p, e_n, e_cep, e_cen, 2'(m_mode), 1'b0, e_pw};
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08b expected %08b (p n cep cen mode stall power) at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check_vec("reset_outs", pack_out(), 8'h00);
    check_vec("reset_outs_nc", pack_nc(), 8'h00);
    @(posedge clock); #1;
    reset = 1'b1;
    m_cnt = 0; m_mode = 0; m_por = 0;
  endtask

  // One clock of model-checked stimulus; called just after a rising edge.
  task automatic sb_cycle(input logic [1:0] t);
    logic [7:0] e;
    turbo = t;
    exp_q.push_back(model_out());
    @(negedge clock);
    e = exp_q.pop_front();
    check_vec("cycle", pack_out(), e);
    if (cep) phase_ceps++;
    last_mode = mode;
    if (e[5]) m_por++;
    if (m_cnt == 15) m_mode = int'(t);
    m_cnt = (m_cnt + 1) % 16;
    @(posedge clock); #1;
  endtask

  task automatic count_cycles(input int n);
    c_cep = 0; c_cen = 0; c_stall = 0; nc_c_cep = 0; nc_c_stall = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      c_cep      += int'(cep);
      c_cen      += int'(cen);
      c_stall    += int'(stall);
      nc_c_cep   += int'(nc_cep);
      nc_c_stall += int'(nc_stall);
      @(posedge clock); #1;
    end
  endtask

  // ---------------- phase table ----------------
  typedef struct {
    logic [1:0] turbo;
    int         ncyc;
    logic [1:0] mode_last;
    int         ceps;
  } phase_t;

  phase_t ph[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ph[0] = '{turbo: 2'd0, ncyc: 32, mode_last: 2'd0, ceps: 2};
    ph[1] = '{turbo: 2'd2, ncyc: 32, mode_last: 2'd2, ceps: 5};
    ph[2] = '{turbo: 2'd0, ncyc: 16, mode_last: 2'd2, ceps: 4};
    ph[3] = '{turbo: 2'd0, ncyc: 5,  mode_last: 2'd0, ceps: 0};
    ph[4] = '{turbo: 2'd3, ncyc: 27, mode_last: 2'd3, ceps: 9};
    ph[5] = '{turbo: 2'd1, ncyc: 4,  mode_last: 2'd3, ceps: 2};
    ph[6] = '{turbo: 2'd2, ncyc: 12, mode_last: 2'd3, ceps: 6};
    ph[7] = '{turbo: 2'd0, ncyc: 16, mode_last: 2'd2, ceps: 4};
    ph[8] = '{turbo: 2'd0, ncyc: 16, mode_last: 2'd0, ceps: 1};

    // Uncontended sequencing and turbo switching, checked every cycle
    do_reset();
    for (int i = 0; i < 9; i++) begin
      phase_ceps = 0;
      for (int c = 0; c < ph[i].ncyc; c++) sb_cycle(ph[i].turbo);
      check_int($sformatf("phase%0d_mode", i), int'(last_mode), int'(ph[i].mode_last));
      check_int($sformatf("phase%0d_ceps", i), phase_ceps, ph[i].ceps);
    end

    // Contention in mode 0: vduCn=1, ah=01, ioula=1, mreq 0 then 1
    turbo = 2'd0; vduCn = 1'b0; ah = 2'b00; mreq = 1'b1; ioula = 1'b1;
    do_reset();
    vduCn = 1'b1; ah = 2'b01; mreq = 1'b0;
    count_cycles(16);
    check_int("cont_a_cep", c_cep, 1);
    check_int("cont_a_cen", c_cen, 1);
    check_int("cont_a_stall", c_stall, 0);
    mreq = 1'b1;
    count_cycles(16);
    check_int("cont_b_cep", c_cep, 1);
    check_int("cont_b_stall", c_stall, 0);
    count_cycles(16);
    check_int("cont_c_cep", c_cep, 0);
    check_int("cont_c_cen", c_cen, 1);
    check_int("cont_c_stall", c_stall, 1);
    count_cycles(16);
    check_int("cont_d_cep", c_cep, 0);
    check_int("cont_d_cen", c_cen, 0);
    check_int("cont_d_stall", c_stall, 2);
    check_int("nocont_d_cep", nc_c_cep, 1);
    check_int("nocont_d_stall", nc_c_stall, 0);
    ah = 2'b10;
    count_cycles(16);
    check_int("cont_e_cep", c_cep, 1);
    check_int("cont_e_cen", c_cen, 1);
    check_int("cont_e_stall", c_stall, 0);
    ioula = 1'b0;
    count_cycles(16);
    check_int("cont_io_cep", c_cep, 0);
    check_int("cont_io_cen", c_cen, 0);
    check_int("cont_io_stall", c_stall, 2);
    ioula = 1'b1;

    // Same contended stimulus in mode 1: no suppression
    vduCn = 1'b0; ah = 2'b00;
    do_reset();
    turbo = 2'd1; vduCn = 1'b1; ah = 2'b01; mreq = 1'b1;
    count_cycles(16);
    count_cycles(32);
    check_int("mode1_cep", c_cep, 4);
    check_int("mode1_cen", c_cen, 4);
    check_int("mode1_stall", c_stall, 0);
    check_int("mode1_mode", int'(mode), 1);

    // Power-on delay: 32 cep pulses at cnt 8 of each period
    turbo = 2'd0; vduCn = 1'b0; ah = 2'b00;
    do_reset();
    c_cep = 0;
    for (int c = 0; c < 510; c++) begin
      @(negedge clock);
      c_cep += int'(cep);
      if (c == 504) begin
        check_int("por_cep_count", c_cep, 32);
        check_int("por_before", int'(power), 0);
      end
      if (c == 505) check_int("por_after", int'(power), 1);
      @(posedge clock); #1;
    end
    check_int("por_hold", int'(power), 1);
    reset = 1'b0;
    @(negedge clock);
    check_vec("midreset_outs", pack_out(), 8'h00);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check_vec("restart_cnt0", pack_out(), 8'b0101_0000);
    @(posedge clock); #1;
    @(negedge clock);
    check_vec("restart_cnt1", pack_out(), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
